// File: rtl/calc_alu_requester_pkg.sv
// Shared definitions for the calculator ALU requester: FSM states, key kinds,
// ALU op codes and error codes.
package calc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GOT_A  = 3'd1,
        ST_GOT_OP = 3'd2,
        ST_GOT_B  = 3'd3,
        ST_ISSUE  = 3'd4,
        ST_WAIT   = 3'd5,
        ST_RESULT = 3'd6
    } state_t;

    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_DIV = 4'b0100;

    localparam logic [1:0] KIND_DIGIT  = 2'b00;
    localparam logic [1:0] KIND_OP     = 2'b01;
    localparam logic [1:0] KIND_EQUALS = 2'b10;
    localparam logic [1:0] KIND_CLEAR  = 2'b11;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_SEQ     = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;
    localparam logic [1:0] ERR_INV_OP  = 2'b11;

    // Division by zero is rejected here so the ALU never sees it.
    function automatic logic op_is_legal(input logic [3:0] op, input logic [3:0] b);
        return (op == OP_ADD) || (op == OP_MUL) || ((op == OP_DIV) && (b != 4'd0));
    endfunction

endpackage

// File: rtl/calc_alu_requester_if.sv
// Keypad, ALU and result-port signals of the requester bundled in one interface.
// master = requester side, slave = environment (keypad, ALU, display) side.
interface calc_alu_requester_if;

    logic       key_valid;
    logic [1:0] key_kind;
    logic [3:0] key_data;
    logic       key_ready;

    logic       alu_sel;
    logic       wr_enable;
    logic [3:0] first_nr;
    logic [3:0] second_nr;
    logic [3:0] operation;
    logic       alu_done;
    logic [7:0] result_uncoded;

    logic       res_valid;
    logic [7:0] res_data;
    logic       res_ready;
    logic [1:0] err_code;

    modport master (
        input  key_valid, key_kind, key_data, alu_done, result_uncoded, res_ready,
        output key_ready, alu_sel, wr_enable, first_nr, second_nr, operation,
               res_valid, res_data, err_code
    );

    modport slave (
        output key_valid, key_kind, key_data, alu_done, result_uncoded, res_ready,
        input  key_ready, alu_sel, wr_enable, first_nr, second_nr, operation,
               res_valid, res_data, err_code
    );

endinterface

// File: rtl/calc_alu_requester_wait_timer.sv
// WAIT-state cycle counter: counts while enabled, flags the last allowed cycle.
module alu_wait_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam logic [7:0] LAST_COUNT = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_count;
    logic       w_at_last;

    assign w_at_last = (r_count == LAST_COUNT);
    assign o_expired = i_enable && w_at_last;

    // Saturates at the last count so a stalled clear cannot wrap it around.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable && !w_at_last) begin
            r_count <= r_count + 8'd1;
        end
    end

endmodule

// File: rtl/calc_alu_requester.sv
// Collects keypad tokens into one ALU operation, runs it with a timeout and
// hands the 8-bit result downstream over a valid/ready port.
module calc_alu_requester
    import calc_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    calc_alu_requester_if.master  bus
);

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_a;
    logic [3:0] w_a_next;
    logic [3:0] r_b;
    logic [3:0] w_b_next;
    logic [3:0] r_op;
    logic [3:0] w_op_next;
    logic [1:0] r_err;
    logic [1:0] w_err_next;
    logic [7:0] r_res;
    logic [7:0] w_res_next;

    logic w_key_ready;
    logic w_accept;
    logic w_in_wait;
    logic w_expired;

    assign w_key_ready = (r_state == ST_IDLE)   || (r_state == ST_GOT_A) ||
                         (r_state == ST_GOT_OP) || (r_state == ST_GOT_B);
    assign w_accept    = bus.key_valid && w_key_ready;
    assign w_in_wait   = (r_state == ST_WAIT);

    alu_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (!w_in_wait),
        .i_enable  (w_in_wait),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_a     <= 4'd0;
            r_b     <= 4'd0;
            r_op    <= 4'd0;
            r_err   <= ERR_NONE;
            r_res   <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_op    <= w_op_next;
            r_err   <= w_err_next;
            r_res   <= w_res_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_op_next    = r_op;
        w_err_next   = r_err;
        w_res_next   = r_res;

        unique case (r_state)
            ST_IDLE, ST_GOT_A, ST_GOT_OP, ST_GOT_B: begin
                if (w_accept) begin
                    if (bus.key_kind == KIND_CLEAR) begin
                        w_state_next = ST_IDLE;
                        w_a_next     = 4'd0;
                        w_b_next     = 4'd0;
                        w_op_next    = 4'd0;
                        w_err_next   = ERR_NONE;
                    end else begin
                        // Any token kind not handled below is dropped and flagged.
                        case (r_state)
                            ST_IDLE: begin
                                if (bus.key_kind == KIND_DIGIT) begin
                                    w_a_next     = bus.key_data;
                                    w_state_next = ST_GOT_A;
                                end else begin
                                    w_err_next = ERR_SEQ;
                                end
                            end
                            ST_GOT_A: begin
                                if (bus.key_kind == KIND_DIGIT) begin
                                    w_a_next = bus.key_data;
                                end else if (bus.key_kind == KIND_OP) begin
                                    w_op_next    = bus.key_data;
                                    w_state_next = ST_GOT_OP;
                                end else begin
                                    w_err_next = ERR_SEQ;
                                end
                            end
                            ST_GOT_OP: begin
                                if (bus.key_kind == KIND_DIGIT) begin
                                    w_b_next     = bus.key_data;
                                    w_state_next = ST_GOT_B;
                                end else begin
                                    w_err_next = ERR_SEQ;
                                end
                            end
                            default: begin
                                if (bus.key_kind == KIND_DIGIT) begin
                                    w_b_next = bus.key_data;
                                end else if (bus.key_kind == KIND_EQUALS) begin
                                    if (op_is_legal(r_op, r_b)) begin
                                        w_state_next = ST_ISSUE;
                                        w_err_next   = ERR_NONE;
                                    end else begin
                                        w_state_next = ST_IDLE;
                                        w_err_next   = ERR_INV_OP;
                                    end
                                end else begin
                                    w_err_next = ERR_SEQ;
                                end
                            end
                        endcase
                    end
                end
            end
            ST_ISSUE: begin
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the final counted cycle beats the timeout.
                if (bus.alu_done) begin
                    w_res_next   = bus.result_uncoded;
                    w_state_next = ST_RESULT;
                end else if (w_expired) begin
                    w_err_next   = ERR_TIMEOUT;
                    w_state_next = ST_IDLE;
                end
            end
            ST_RESULT: begin
                if (bus.res_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign bus.key_ready = w_key_ready;
    assign bus.alu_sel   = (r_state == ST_ISSUE) || (r_state == ST_WAIT);
    assign bus.wr_enable = (r_state == ST_ISSUE);
    assign bus.first_nr  = r_a;
    assign bus.second_nr = r_b;
    assign bus.operation = r_op;
    assign bus.res_valid = (r_state == ST_RESULT);
    assign bus.res_data  = r_res;
    assign bus.err_code  = r_err;

endmodule

// File: tb/tb_calc_alu_requester.sv
// Bench for calc_alu_requester: table vectors, hand-written ALU sequences and
// random keypad sessions checked against a token-level reference model.
module tb_calc_alu_requester;

    localparam int T = 16;

    localparam logic [1:0] K_DIG = 2'd0;
    localparam logic [1:0] K_OP  = 2'd1;
    localparam logic [1:0] K_EQ  = 2'd2;
    localparam logic [1:0] K_CLR = 2'd3;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    calc_alu_requester_if bus ();

    calc_alu_requester #(
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model state: collected fields plus "have" flags.
    int m_a, m_b, m_op, m_err;
    bit h_a, h_op, h_b;

    typedef struct {
        logic [1:0] kind;
        logic [3:0] data;
        logic [1:0] err;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] op;
    } vec_t;

    vec_t vecs[18];

    function automatic vec_t mk(input logic [1:0] kind, input logic [3:0] data,
                                input logic [1:0] err, input logic [3:0] a,
                                input logic [3:0] b, input logic [3:0] op);
        vec_t v;
        v.kind = kind; v.data = data; v.err = err; v.a = a; v.b = b; v.op = op;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_err = 0;
        h_a = 0; h_op = 0; h_b = 0;
    endtask

    task automatic model_token(input logic [1:0] kind, input logic [3:0] data, output bit issue);
        issue = 0;
        case (kind)
            K_CLR: model_reset();
            K_DIG: begin
                if (!h_a) begin
                    m_a = int'(data); h_a = 1;
                end else if (!h_op) begin
                    m_a = int'(data);
                end else begin
                    m_b = int'(data); h_b = 1;
                end
            end
            K_OP: begin
                if (h_a && !h_op) begin
                    m_op = int'(data); h_op = 1;
                end else begin
                    m_err = 1;
                end
            end
            default: begin
                if (h_b) begin
                    h_a = 0; h_op = 0; h_b = 0;
                    if (m_op == 1 || m_op == 2 || (m_op == 4 && m_b != 0)) begin
                        issue = 1; m_err = 0;
                    end else begin
                        m_err = 3;
                    end
                end else begin
                    m_err = 1;
                end
            end
        endcase
    endtask

    task automatic send_tok(input logic [1:0] kind, input logic [3:0] data);
        bus.key_valid = 1'b1;
        bus.key_kind  = kind;
        bus.key_data  = data;
        @(posedge clk); #1;
        bus.key_valid = 1'b0;
        bus.key_kind  = 2'($urandom);
        bus.key_data  = 4'($urandom);
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_key_ready"}, bus.key_ready, 1);
        chk({tag, "_alu_sel"},   bus.alu_sel, 0);
        chk({tag, "_res_valid"}, bus.res_valid, 0);
        chk({tag, "_err"},       bus.err_code, m_err);
        chk({tag, "_a"},         bus.first_nr, m_a);
        chk({tag, "_b"},         bus.second_nr, m_b);
        chk({tag, "_op"},        bus.operation, m_op);
    endtask

    // Entered one cycle after equals was accepted (DUT expected in ISSUE).
    // lat = WAIT-cycle index at which alu_done is driven; lat >= T means never.
    task automatic run_alu(input int lat, input logic [7:0] res, input int rdy);
        int sel_n, wr_n, k, exp_wait;
        chk("issue_wr", bus.wr_enable, 1);
        chk("issue_sel", bus.alu_sel, 1);
        chk("issue_a", bus.first_nr, m_a);
        chk("issue_b", bus.second_nr, m_b);
        chk("issue_op", bus.operation, m_op);
        bus.alu_done       = 1'($urandom);
        bus.result_uncoded = ~res;
        @(posedge clk); #1;
        sel_n = 0; wr_n = 0; k = 0;
        while (bus.alu_sel && k < T + 8) begin
            sel_n++;
            if (bus.wr_enable) wr_n++;
            chk("wait_a", bus.first_nr, m_a);
            chk("wait_op", bus.operation, m_op);
            bus.alu_done       = (k == lat);
            bus.result_uncoded = (k == lat) ? res : 8'($urandom);
            bus.key_valid      = 1'($urandom);
            bus.key_kind       = 2'($urandom);
            bus.key_data       = 4'($urandom);
            @(posedge clk); #1;
            k++;
        end
        bus.alu_done  = 1'b0;
        bus.key_valid = 1'b0;
        exp_wait = (lat < T) ? lat + 1 : T;
        chk("wait_cycles", sel_n, exp_wait);
        chk("wait_wr_pulses", wr_n, 0);
        if (lat < T) begin
            for (int c = 0; c < rdy; c++) begin
                chk("hold_valid", bus.res_valid, 1);
                chk("hold_data", bus.res_data, res);
                chk("hold_key_ready", bus.key_ready, 0);
                bus.key_valid = 1'($urandom);
                bus.key_kind  = 2'($urandom);
                @(posedge clk); #1;
            end
            chk("res_valid", bus.res_valid, 1);
            chk("res_data", bus.res_data, res);
            bus.res_ready = 1'b1;
            @(posedge clk); #1;
            bus.res_ready = 1'b0;
            bus.key_valid = 1'b0;
            chk("post_valid", bus.res_valid, 0);
            chk("post_key_ready", bus.key_ready, 1);
            chk("post_err", bus.err_code, 0);
            $display("txn a=%0d op=%0d b=%0d result=0x%02h wait=%0d", m_a, m_op, m_b, res, sel_n);
        end else begin
            m_err = 2;
            chk("timeout_err", bus.err_code, 2);
            chk("timeout_valid", bus.res_valid, 0);
            chk("timeout_key_ready", bus.key_ready, 1);
            $display("txn a=%0d op=%0d b=%0d timeout wait=%0d", m_a, m_op, m_b, sel_n);
        end
    endtask

    task automatic do_tok(input logic [1:0] kind, input logic [3:0] data, output bit issue);
        send_tok(kind, data);
        model_token(kind, data, issue);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit iss;
        int r, lat;
        logic [1:0] kind;
        logic [3:0] data;

        rst = 1'b1;
        bus.key_valid = 0; bus.key_kind = 0; bus.key_data = 0;
        bus.alu_done = 0; bus.result_uncoded = 0; bus.res_ready = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_key_ready", bus.key_ready, 1);
        chk("rst_alu_sel", bus.alu_sel, 0);
        chk("rst_wr", bus.wr_enable, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_err", bus.err_code, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_idle("idle0");

        // Token vectors with no ALU request; expectations derived by hand.
        vecs[0]  = mk(K_EQ,  4'd0, 2'd1, 4'd0, 4'd0, 4'd0);
        vecs[1]  = mk(K_DIG, 4'd6, 2'd1, 4'd6, 4'd0, 4'd0);
        vecs[2]  = mk(K_CLR, 4'd0, 2'd0, 4'd0, 4'd0, 4'd0);
        vecs[3]  = mk(K_DIG, 4'd4, 2'd0, 4'd4, 4'd0, 4'd0);
        vecs[4]  = mk(K_OP,  4'd4, 2'd0, 4'd4, 4'd0, 4'd4);
        vecs[5]  = mk(K_DIG, 4'd0, 2'd0, 4'd4, 4'd0, 4'd4);
        vecs[6]  = mk(K_EQ,  4'd0, 2'd3, 4'd4, 4'd0, 4'd4);
        vecs[7]  = mk(K_DIG, 4'd4, 2'd3, 4'd4, 4'd0, 4'd4);
        vecs[8]  = mk(K_OP,  4'd8, 2'd3, 4'd4, 4'd0, 4'd8);
        vecs[9]  = mk(K_DIG, 4'd5, 2'd3, 4'd4, 4'd5, 4'd8);
        vecs[10] = mk(K_EQ,  4'd0, 2'd3, 4'd4, 4'd5, 4'd8);
        vecs[11] = mk(K_CLR, 4'd0, 2'd0, 4'd0, 4'd0, 4'd0);
        vecs[12] = mk(K_OP,  4'd1, 2'd1, 4'd0, 4'd0, 4'd0);
        vecs[13] = mk(K_DIG, 4'd2, 2'd1, 4'd2, 4'd0, 4'd0);
        vecs[14] = mk(K_EQ,  4'd0, 2'd1, 4'd2, 4'd0, 4'd0);
        vecs[15] = mk(K_OP,  4'd1, 2'd1, 4'd2, 4'd0, 4'd1);
        vecs[16] = mk(K_OP,  4'd2, 2'd1, 4'd2, 4'd0, 4'd1);
        vecs[17] = mk(K_CLR, 4'd0, 2'd0, 4'd0, 4'd0, 4'd0);
        for (int i = 0; i < 18; i++) begin
            do_tok(vecs[i].kind, vecs[i].data, iss);
            chk($sformatf("vec%0d_err", i), bus.err_code, vecs[i].err);
            chk($sformatf("vec%0d_a", i), bus.first_nr, vecs[i].a);
            chk($sformatf("vec%0d_b", i), bus.second_nr, vecs[i].b);
            chk($sformatf("vec%0d_op", i), bus.operation, vecs[i].op);
            chk($sformatf("vec%0d_key_ready", i), bus.key_ready, 1);
            chk($sformatf("vec%0d_alu_sel", i), bus.alu_sel, 0);
        end

        // 3 + 5, done two cycles after ISSUE.
        do_tok(K_DIG, 4'd3, iss); do_tok(K_OP, 4'd1, iss);
        do_tok(K_DIG, 4'd5, iss); do_tok(K_EQ, 4'd0, iss);
        chk("add_issue", iss, 1);
        chk("add_a", bus.first_nr, 3);
        chk("add_b", bus.second_nr, 5);
        run_alu(1, 8'h08, 0);

        // Last digit wins for A; result held with res_ready low for 5 cycles.
        do_tok(K_DIG, 4'd7, iss); do_tok(K_DIG, 4'd9, iss); do_tok(K_OP, 4'd2, iss);
        do_tok(K_DIG, 4'd15, iss); do_tok(K_EQ, 4'd0, iss);
        chk("mul_a", bus.first_nr, 9);
        chk("mul_op", bus.operation, 2);
        run_alu(0, 8'h87, 5);

        // ALU never answers: timeout, then done coinciding with the last cycle.
        do_tok(K_DIG, 4'd2, iss); do_tok(K_OP, 4'd1, iss);
        do_tok(K_DIG, 4'd2, iss); do_tok(K_EQ, 4'd0, iss);
        run_alu(T + 100, 8'h00, 0);
        check_idle("after_timeout");
        do_tok(K_DIG, 4'd1, iss); do_tok(K_OP, 4'd4, iss);
        do_tok(K_DIG, 4'd3, iss); do_tok(K_EQ, 4'd0, iss);
        chk("edge_issue", iss, 1);
        run_alu(T - 1, 8'h5A, 1);

        // Reset asserted in the middle of WAIT.
        do_tok(K_DIG, 4'd1, iss); do_tok(K_OP, 4'd1, iss);
        do_tok(K_DIG, 4'd1, iss); do_tok(K_EQ, 4'd0, iss);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("pre_rst_sel", bus.alu_sel, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_sel", bus.alu_sel, 0);
        chk("mid_rst_wr", bus.wr_enable, 0);
        chk("mid_rst_key_ready", bus.key_ready, 1);
        chk("mid_rst_a", bus.first_nr, 0);
        chk("mid_rst_op", bus.operation, 0);
        bus.alu_done = 1'b1; bus.result_uncoded = 8'hAA;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk("post_rst_valid", bus.res_valid, 0);
            chk("post_rst_sel", bus.alu_sel, 0);
            chk("post_rst_wr", bus.wr_enable, 0);
        end
        bus.alu_done = 1'b0;
        check_idle("post_rst");
        do_tok(K_DIG, 4'd5, iss); do_tok(K_OP, 4'd2, iss);
        do_tok(K_DIG, 4'd3, iss); do_tok(K_EQ, 4'd0, iss);
        chk("post_rst_issue", iss, 1);
        run_alu(2, 8'd15, 1);

        // Random keypad sessions against the reference model.
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                kind = K_DIG; data = 4'($urandom);
            end else if (r < 7) begin
                kind = K_OP;
                case ($urandom_range(0, 3))
                    0: data = 4'd1;
                    1: data = 4'd2;
                    2: data = 4'd4;
                    default: data = 4'($urandom);
                endcase
            end else if (r < 9) begin
                kind = K_EQ; data = 4'($urandom);
            end else begin
                kind = K_CLR; data = 4'($urandom);
            end
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk); #1;
            end
            do_tok(kind, data, iss);
            if (iss) begin
                r = $urandom_range(0, 9);
                if (r < 7)       lat = $urandom_range(0, 5);
                else if (r == 7) lat = T - 1;
                else if (r == 8) lat = T + 100;
                else             lat = T - 2;
                run_alu(lat, 8'($urandom), $urandom_range(0, 3));
            end else begin
                check_idle("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
